// File: rtl/jt900h_memctl_if.sv
// Bus bundle between the jt900h core load/store port, this controller and 16-bit external memory.
// master = core + memory side, slave = the memory controller.
interface jt900h_memctl_if #(
  parameter int AW = 24
);
  logic          cen;
  logic          cpu_req;
  logic          cpu_we;
  logic [1:0]    cpu_size;
  logic [AW-1:0] cpu_addr;
  logic [31:0]   cpu_wdata;
  logic          busy;
  logic          cpu_ack;
  logic          cpu_err;
  logic [31:0]   cpu_rdata;
  logic [AW-1:0] ram_addr;
  logic [15:0]   ram_din;
  logic [15:0]   ram_dout;
  logic [1:0]    ram_we;
  logic          ram_rdy;

  modport master (
    output cen, cpu_req, cpu_we, cpu_size, cpu_addr, cpu_wdata, ram_dout, ram_rdy,
    input  busy, cpu_ack, cpu_err, cpu_rdata, ram_addr, ram_din, ram_we
  );

  modport slave (
    input  cen, cpu_req, cpu_we, cpu_size, cpu_addr, cpu_wdata, ram_dout, ram_rdy,
    output busy, cpu_ack, cpu_err, cpu_rdata, ram_addr, ram_din, ram_we
  );
endinterface

// File: rtl/jt900h_memctl.sv
// Splits byte/word/long CPU accesses at any alignment into 1-3 little-endian 16-bit beats,
// reassembles read data and aborts beats stalled on ram_rdy via a watchdog.
module jt900h_memctl #(
  parameter int AW   = 24,
  parameter int TOUT = 255
) (
  input logic          clk,
  input logic          rst_n,
  jt900h_memctl_if.slave bus
);
  localparam int TW = (TOUT > 1) ? $clog2(TOUT) : 1;

  typedef enum logic [1:0] {IDLE, BEAT, ACK} state_t;

  state_t        st;
  logic [AW-1:0] addr_q;
  logic [1:0]    size_q;
  logic          we_q;
  logic [31:0]   wdata_q;
  logic [1:0]    k;
  logic [1:0]    lane_q;
  logic [TW-1:0] wd;
  logic [47:0]   acc;

  logic [AW-1:0] s_addr, b_addr;
  logic [1:0]    s_size, s_k, s_n, n_q, b_we;
  logic [31:0]   s_wdata, rd32;
  logic          s_odd, last, abort;
  logic [47:0]   s_sh, acc_n;
  logic [15:0]   b_din;

  function automatic logic [1:0] nbeats(input logic [1:0] size, input logic odd);
    if (size == 2'd0)      return 2'd1;
    else if (size == 2'd1) return odd ? 2'd2 : 2'd1;
    else                   return odd ? 2'd3 : 2'd2;
  endfunction

  // Plan for the beat about to start: the first one from the live request in IDLE,
  // otherwise the one after the current beat from the latched request.
  always_comb begin
    if (st == IDLE) begin
      s_addr  = bus.cpu_addr;
      s_size  = bus.cpu_size;
      s_wdata = bus.cpu_wdata;
      s_k     = 2'd0;
    end else begin
      s_addr  = addr_q;
      s_size  = size_q;
      s_wdata = wdata_q;
      s_k     = k + 2'd1;
    end
    s_odd  = s_addr[0];
    s_n    = nbeats(s_size, s_odd);
    b_addr = {s_addr[AW-1:1], 1'b0} + {{(AW-3){1'b0}}, s_k, 1'b0};
    s_sh   = s_odd ? {8'h00, s_wdata, 8'h00} : {16'h0000, s_wdata};
    case (s_k)
      2'd0:    b_din = s_sh[15:0];
      2'd1:    b_din = s_sh[31:16];
      default: b_din = s_sh[47:32];
    endcase
    if (!s_odd)                 b_we = (s_size == 2'd0) ? 2'b01 : 2'b11;
    else if (s_k == 2'd0)       b_we = 2'b10;
    else if (s_k == s_n - 2'd1) b_we = 2'b01;
    else                        b_we = 2'b11;

    n_q   = nbeats(size_q, addr_q[0]);
    last  = (k == n_q - 2'd1);
    abort = (TOUT != 0) && !bus.ram_rdy && (wd == TW'(TOUT - 1));

    acc_n = acc;
    case (k)
      2'd0:    acc_n[15:0]  = bus.ram_dout;
      2'd1:    acc_n[31:16] = bus.ram_dout;
      default: acc_n[47:32] = bus.ram_dout;
    endcase
    rd32 = addr_q[0] ? acc_n[39:8] : acc_n[31:0];
    case (size_q)
      2'd0:    rd32 = {24'h000000, rd32[7:0]};
      2'd1:    rd32 = {16'h0000, rd32[15:0]};
      default: rd32 = rd32;
    endcase
  end

  // Lanes only reach memory on enabled edges of a live beat.
  assign bus.ram_we = (st == BEAT && bus.cen) ? lane_q : 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st            <= IDLE;
      addr_q        <= '0;
      size_q        <= 2'd0;
      we_q          <= 1'b0;
      wdata_q       <= 32'd0;
      k             <= 2'd0;
      lane_q        <= 2'b00;
      wd            <= '0;
      acc           <= 48'd0;
      bus.busy      <= 1'b0;
      bus.cpu_ack   <= 1'b0;
      bus.cpu_err   <= 1'b0;
      bus.cpu_rdata <= 32'd0;
      bus.ram_addr  <= '0;
      bus.ram_din   <= 16'd0;
    end else if (bus.cen) begin
      case (st)
        IDLE: if (bus.cpu_req) begin
          st           <= BEAT;
          addr_q       <= bus.cpu_addr;
          size_q       <= bus.cpu_size;
          we_q         <= bus.cpu_we;
          wdata_q      <= bus.cpu_wdata;
          k            <= 2'd0;
          wd           <= '0;
          acc          <= 48'd0;
          bus.busy     <= 1'b1;
          bus.ram_addr <= b_addr;
          bus.ram_din  <= b_din;
          lane_q       <= bus.cpu_we ? b_we : 2'b00;
        end
        BEAT: begin
          if (bus.ram_rdy) begin
            acc <= acc_n;
            if (last) begin
              st            <= ACK;
              bus.cpu_ack   <= 1'b1;
              bus.cpu_err   <= 1'b0;
              bus.cpu_rdata <= we_q ? 32'd0 : rd32;
            end else begin
              k            <= s_k;
              wd           <= '0;
              bus.ram_addr <= b_addr;
              bus.ram_din  <= b_din;
              lane_q       <= we_q ? b_we : 2'b00;
            end
          end else if (abort) begin
            st            <= ACK;
            bus.cpu_ack   <= 1'b1;
            bus.cpu_err   <= 1'b1;
            bus.cpu_rdata <= 32'd0;
          end else begin
            wd <= wd + TW'(1);
          end
        end
        default: begin
          st          <= IDLE;
          bus.busy    <= 1'b0;
          bus.cpu_ack <= 1'b0;
          bus.cpu_err <= 1'b0;
        end
      endcase
    end
  end
endmodule
